// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// The optional lock-loss counters are enabled with PLL_SUP_LOSS_CNT_EN.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET,
        WAIT_LOCK,
        DEBOUNCE,
        LOCKED,
        FAIL
    } sup_state_t;

    localparam int LOSS_CNT_W = 8;

    // Width of a counter that must hold values 0..max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pll_sup_channel.sv
// One supervised PLL: lock synchroniser, reset/lock FSM, retry bookkeeping.
// With PLL_SUP_LOSS_CNT_EN defined, also counts LOCKED->RESET lock losses.
module pll_sup_channel
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYCLES   = 64,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int MAX_RETRY          = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear_fail,
    input  logic pll_lock,
    output logic pll_rst,
    output logic pll_pwd,
    output logic ch_ready,
    output logic ch_fail
`ifdef PLL_SUP_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W-1:0] loss_cnt
`endif
);

    localparam int RCNT_W  = cnt_width(RST_PULSE_CYCLES);
    localparam int TCNT_W  = cnt_width(LOCK_TIMEOUT);
    localparam int SCNT_W  = cnt_width(LOCK_STABLE_CYCLES);
    localparam int RETRY_W = cnt_width(MAX_RETRY);

    localparam logic [RCNT_W-1:0]  RCNT_LOAD = RCNT_W'(RST_PULSE_CYCLES);
    localparam logic [TCNT_W-1:0]  TCNT_LAST = TCNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [SCNT_W-1:0]  SCNT_LAST = SCNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    sup_state_t         state;
    logic [RCNT_W-1:0]  rcnt;
    logic [TCNT_W-1:0]  tcnt;
    logic [SCNT_W-1:0]  scnt;
    logic [RETRY_W-1:0] retry;
    logic               lock_meta;
    logic               lock_s;

    // NOTE: non-blocking assignments keep these as two distinct flops; a
    // blocking pair would collapse into a single synchroniser stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET;
            rcnt  <= RCNT_LOAD;
            tcnt  <= '0;
            scnt  <= '0;
            retry <= '0;
        end else if (!enable) begin
            state <= RESET;
            rcnt  <= RCNT_LOAD;
            tcnt  <= '0;
            scnt  <= '0;
            retry <= '0;
        end else begin
            case (state)
                RESET: begin
                    if (rcnt == RCNT_W'(1)) begin
                        state <= WAIT_LOCK;
                        tcnt  <= '0;
                    end else begin
                        rcnt <= rcnt - RCNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= DEBOUNCE;
                        scnt  <= SCNT_W'(1);
                    end else if (tcnt == TCNT_LAST) begin
                        retry <= retry + RETRY_W'(1);
                        if (retry + RETRY_W'(1) == RETRY_MAX) begin
                            state <= FAIL;
                        end else begin
                            state <= RESET;
                            rcnt  <= RCNT_LOAD;
                        end
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                DEBOUNCE: begin
                    // The timeout keeps running through lock glitches so a
                    // chattering lock still ends in a retry.
                    if (tcnt != TCNT_LAST) begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (scnt == SCNT_LAST) begin
                        state <= LOCKED;
                        retry <= '0;
                    end else begin
                        scnt <= scnt + SCNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (!lock_s) begin
                        state <= RESET;
                        rcnt  <= RCNT_LOAD;
                    end
                end
                FAIL: begin
                    if (clear_fail) begin
                        state <= RESET;
                        rcnt  <= RCNT_LOAD;
                        retry <= '0;
                    end
                end
                default: begin
                    state <= RESET;
                    rcnt  <= RCNT_LOAD;
                end
            endcase
        end
    end

    assign pll_rst  = (state == RESET) || (state == FAIL);
    assign pll_pwd  = (state == FAIL);
    assign ch_ready = (state == LOCKED);
    assign ch_fail  = (state == FAIL);

`ifdef PLL_SUP_LOSS_CNT_EN
    // Only a genuine lock loss counts; enable-forced exits from LOCKED do not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_cnt <= '0;
        end else if (enable && state == LOCKED && !lock_s && loss_cnt != '1) begin
            loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/pll_lock_supervisor.sv
// Top of the PLL lock supervisor: NUM_PLL independent channels plus all_ready.
// Defining PLL_SUP_LOSS_CNT_EN adds the per-channel loss_cnt output.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int NUM_PLL            = 2,
    parameter int RST_PULSE_CYCLES   = 64,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int MAX_RETRY          = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [NUM_PLL-1:0] clear_fail,
    input  logic [NUM_PLL-1:0] pll_lock,
    output logic [NUM_PLL-1:0] pll_rst,
    output logic [NUM_PLL-1:0] pll_pwd,
    output logic [NUM_PLL-1:0] ch_ready,
    output logic [NUM_PLL-1:0] ch_fail,
    output logic               all_ready
`ifdef PLL_SUP_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W*NUM_PLL-1:0] loss_cnt
`endif
);

    for (genvar i = 0; i < NUM_PLL; i++) begin : g_ch
        pll_sup_channel #(
            .RST_PULSE_CYCLES  (RST_PULSE_CYCLES),
            .LOCK_TIMEOUT      (LOCK_TIMEOUT),
            .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
            .MAX_RETRY         (MAX_RETRY)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .enable    (enable),
            .clear_fail(clear_fail[i]),
            .pll_lock  (pll_lock[i]),
            .pll_rst   (pll_rst[i]),
            .pll_pwd   (pll_pwd[i]),
            .ch_ready  (ch_ready[i]),
            .ch_fail   (ch_fail[i])
`ifdef PLL_SUP_LOSS_CNT_EN
            ,
            .loss_cnt  (loss_cnt[LOSS_CNT_W*i +: LOSS_CNT_W])
`endif
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_ready <= 1'b0;
        end else begin
            all_ready <= &ch_ready;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short reset/timeout parameters.
// Loss-counter checks run only when PLL_SUP_LOSS_CNT_EN is defined.
module tb_pll_lock_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] clear_fail;
    logic [1:0] pll_lock;
    logic [1:0] pll_rst;
    logic [1:0] pll_pwd;
    logic [1:0] ch_ready;
    logic [1:0] ch_fail;
    logic       all_ready;
`ifdef PLL_SUP_LOSS_CNT_EN
    logic [15:0] loss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .NUM_PLL           (2),
        .RST_PULSE_CYCLES  (4),
        .LOCK_TIMEOUT      (32),
        .LOCK_STABLE_CYCLES(16),
        .MAX_RETRY         (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .clear_fail(clear_fail),
        .pll_lock  (pll_lock),
        .pll_rst   (pll_rst),
        .pll_pwd   (pll_pwd),
        .ch_ready  (ch_ready),
        .ch_fail   (ch_fail),
        .all_ready (all_ready)
`ifdef PLL_SUP_LOSS_CNT_EN
        ,
        .loss_cnt  (loss_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        int rises;
        logic prev;
        logic timed_out;
        logic saw_ready;

        rst        = 1'b1;
        enable     = 1'b0;
        clear_fail = 2'b00;
        pll_lock   = 2'b00;
        repeat (3) tick();
        check("rst_pll_rst", pll_rst, 3);
        check("rst_pll_pwd", pll_pwd, 0);
        check("rst_ch_ready", ch_ready, 0);
        check("rst_ch_fail", ch_fail, 0);
        check("rst_all_ready", all_ready, 0);

        // 1: reset pulse length and lock-to-ready latency on ch0
        rst    = 1'b0;
        enable = 1'b1;
        cnt = 0;
        while (pll_rst[0] && cnt < 20) begin
            cnt++;
            tick();
        end
        check("t1_rst_pulse", cnt, 4);
        repeat (5) tick();
        pll_lock[0] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!ch_ready[0] && n < 60);
        check("t1_ready_lat", n, 19);

        // 2: all_ready follows both channels, lock loss on ch1
        pll_lock[1] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!ch_ready[1] && n < 60);
        check("t2_ready1_lat", n, 19);
        check("t2_all_before", all_ready, 0);
        tick();
        check("t2_all_after", all_ready, 1);
        pll_lock[1] = 1'b0;
        n = 0;
        do begin tick(); n++; end while (ch_ready[1] && n < 20);
        check("t2_loss_lat", n, 3);
        check("t2_all_lag", all_ready, 1);
        cnt = 1;
        tick();
        check("t2_all_drop", all_ready, 0);
        while (pll_rst[1] && cnt < 20) begin
            cnt++;
            tick();
        end
        check("t2_rst_pulse1", cnt, 4);

        // 4: ch1 never locks -> three attempts then FAIL
        n = 0;
        rises = 0;
        prev = pll_rst[1];
        do begin
            tick();
            n++;
            if (pll_rst[1] && !prev) rises++;
            prev = pll_rst[1];
        end while (!ch_fail[1] && n < 300);
        check("t4_fail_lat", n, 104);
        check("t4_rst_rises", rises, 3);
        check("t4_pwd1", pll_pwd[1], 1);
        check("t4_rst1", pll_rst[1], 1);
        check("t4_ch0_ready", ch_ready[0], 1);
        check("t4_ch0_fail", ch_fail[0], 0);
        check("t4_all_ready", all_ready, 0);

        clear_fail = 2'b01;
        tick();
        clear_fail = 2'b00;
        tick();
        check("t4_clr_ignored", ch_ready[0], 1);
        check("t4_clr_other", ch_fail[1], 1);

        clear_fail = 2'b10;
        tick();
        clear_fail = 2'b00;
        check("t4_clr_fail", ch_fail[1], 0);
        check("t4_clr_pwd", pll_pwd[1], 0);
        cnt = 0;
        while (pll_rst[1] && cnt < 20) begin
            cnt++;
            tick();
        end
        check("t4_clr_pulse", cnt, 4);
        n = 0;
        do begin tick(); n++; end while (!ch_fail[1] && n < 300);
        check("t4_refail_lat", n, 104);

        // enable low forces RESET everywhere and clears FAIL
        enable = 1'b0;
        tick();
        check("en_fail_clr", ch_fail[1], 0);
        check("en_pll_rst", pll_rst, 3);
        check("en_ready0", ch_ready[0], 0);
        enable = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!ch_ready[0] && n < 80);
        check("en_relock_lat", n, 21);

        // 3: chattering lock restarts debounce
        pll_lock[0] = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!pll_rst[0] && n < 20);
        check("t3_loss_rst", n, 3);
        while (pll_rst[0] && n < 40) begin
            tick();
            n++;
        end
        pll_lock[0] = 1'b1;
        repeat (10) tick();
        check("t3_no_early", ch_ready[0], 0);
        pll_lock[0] = 1'b0;
        tick();
        pll_lock[0] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!ch_ready[0] && n < 60);
        check("t3_debounce_lat", n, 19);

        // 3b: lock that never stays high long enough still times out
        pll_lock[0] = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!pll_rst[0] && n < 20);
        while (pll_rst[0] && n < 40) begin
            tick();
            n++;
        end
        timed_out = 1'b0;
        saw_ready = 1'b0;
        for (int i = 0; i < 120 && !timed_out; i++) begin
            pll_lock[0] = ((i % 16) < 8);
            tick();
            if (pll_rst[0]) timed_out = 1'b1;
            if (ch_ready[0]) saw_ready = 1'b1;
        end
        check("t3_timeout", timed_out, 1);
        check("t3_no_ready", saw_ready, 0);
        pll_lock[0] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!ch_ready[0] && n < 100);
        check("t3_relock", ch_ready[0], 1);
        check("t3_ch0_fail", ch_fail[0], 0);

        // 5: asynchronous reset while LOCKED
        #2;
        rst = 1'b1;
        #1;
        check("t5_pll_rst", pll_rst, 3);
        check("t5_pll_pwd", pll_pwd, 0);
        check("t5_ch_ready", ch_ready, 0);
        check("t5_ch_fail", ch_fail, 0);
        check("t5_all_ready", all_ready, 0);
        repeat (2) tick();

`ifdef PLL_SUP_LOSS_CNT_EN
        // 6: loss counter saturation and clearing
        begin
            int expired;
            expired = 0;
            rst = 1'b0;
            enable = 1'b1;
            pll_lock = 2'b01;
            for (int k = 0; k < 300; k++) begin
                n = 0;
                do begin tick(); n++; end while (!ch_ready[0] && n < 80);
                if (!ch_ready[0]) expired++;
                pll_lock[0] = 1'b0;
                n = 0;
                do begin tick(); n++; end while (ch_ready[0] && n < 20);
                if (ch_ready[0]) expired++;
                pll_lock[0] = 1'b1;
                if (k == 2) check("t6_loss3", loss_cnt[7:0], 3);
            end
            check("t6_waits", expired, 0);
            check("t6_loss_sat", loss_cnt[7:0], 255);
            check("t6_loss_ch1", loss_cnt[15:8], 0);
            enable = 1'b0;
            repeat (2) tick();
            enable = 1'b1;
            tick();
            check("t6_loss_en", loss_cnt[7:0], 255);
            rst = 1'b1;
            #1;
            check("t6_loss_rst", loss_cnt[7:0], 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
